// File: rtl/spu_host_pkg.sv
// Shared constants and payload types for the SPU host-side sequencer.
package spu_host_pkg;

  localparam logic [1:0] OP_MANHATTAN = 2'b00;
  localparam logic [1:0] OP_AREA      = 2'b01;
  localparam logic [1:0] OP_RSVD2     = 2'b10;
  localparam logic [1:0] OP_RSVD3     = 2'b11;

  localparam logic [7:0] IDLE_UIO = 8'hC0;

  localparam int unsigned A_LSB  = 0;
  localparam int unsigned A_W    = 4;
  localparam int unsigned B_LSB  = 4;
  localparam int unsigned B_W    = 4;
  localparam int unsigned C_LSB  = 0;
  localparam int unsigned C_W    = 3;
  localparam int unsigned D_LSB  = 3;
  localparam int unsigned D_W    = 3;
  localparam int unsigned OP_LSB = 6;
  localparam int unsigned OP_W   = 2;

  localparam int unsigned RSP_W = 10;

  typedef struct packed {
    logic [1:0] op;
    logic [2:0] d;
    logic [2:0] c;
    logic [3:0] b;
    logic [3:0] a;
  } cmd_t;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] data;
  } rsp_t;

  function automatic logic [7:0] pack_ui(input cmd_t cmd);
    logic [7:0] p;
    p = '0;
    p[A_LSB +: A_W] = cmd.a;
    p[B_LSB +: B_W] = cmd.b;
    return p;
  endfunction

  function automatic logic [7:0] pack_uio(input cmd_t cmd);
    logic [7:0] p;
    p = '0;
    p[C_LSB +: C_W]   = cmd.c;
    p[D_LSB +: D_W]   = cmd.d;
    p[OP_LSB +: OP_W] = cmd.op;
    return p;
  endfunction

  function automatic logic is_rsvd(input logic [1:0] op);
    return (op == OP_RSVD2) || (op == OP_RSVD3);
  endfunction

endpackage

// File: rtl/spu_host_sequencer_if.sv
// Command and response streams between the harness and the SPU host sequencer.
interface spu_host_sequencer_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] cmd_c;
  logic [2:0] cmd_d;
  logic [1:0] cmd_op;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_op;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_c, cmd_d, cmd_op, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_op
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_c, cmd_d, cmd_op, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_op
  );

endinterface

// File: rtl/spu_host_rsp_fifo.sv
// Synchronous FIFO with occupancy count; head is visible on rd_data while non-empty.
module spu_host_rsp_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic [WIDTH-1:0]                 wr_data,
  input  logic                             rd_en,
  output logic [WIDTH-1:0]                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_rd;
  logic             do_wr;

  // A read frees the slot the same cycle, so write-on-full with a read is legal.
  assign do_rd = rd_en & (count_q != '0);
  assign do_wr = wr_en & ((count_q != CW'(DEPTH)) | do_rd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign count   = count_q;

endmodule

// File: rtl/spu_host_sequencer.sv
// Host-side SPU initiator: drives pins for one cycle per command, tracks the fixed
// SPU latency and captures uo_out into a credit-protected response FIFO.
module spu_host_sequencer
  import spu_host_pkg::*;
#(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  spu_host_sequencer_if.slave   host,
  output logic [7:0]            spu_ui_in,
  output logic [7:0]            spu_uio_in,
  input  logic [7:0]            spu_uo_out,
  output logic                  spu_rst_n,
  output logic                  err_nonzero,
  output logic [2:0]            inflight
);

  localparam int unsigned STAGES = LATENCY + 1;
  localparam int unsigned CRED_W = $clog2(FIFO_DEPTH + 1);

  cmd_t              cmd;
  logic              accept;
  logic              pop;
  logic              cmd_ready_q;
  logic [CRED_W-1:0] credits;
  logic [CRED_W-1:0] credits_next;
  logic [STAGES-1:0] stg_vld;
  logic [1:0]        stg_op [STAGES];
  logic              capture;
  logic [1:0]        cap_op;
  logic [CRED_W-1:0] fifo_count;
  rsp_t              fifo_wdata;
  rsp_t              fifo_head;

  assign cmd    = {host.cmd_op, host.cmd_d, host.cmd_c, host.cmd_b, host.cmd_a};
  assign accept = host.cmd_valid & cmd_ready_q;
  assign pop    = host.rsp_valid & host.rsp_ready;

  // Credits cover every slot a command may occupy: pipeline stage or FIFO entry.
  always_comb begin
    credits_next = credits;
    unique case ({accept, pop})
      2'b10:   credits_next = credits - CRED_W'(1);
      2'b01:   credits_next = credits + CRED_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spu_rst_n   <= 1'b0;
      credits     <= CRED_W'(FIFO_DEPTH);
      cmd_ready_q <= 1'b0;
    end else begin
      spu_rst_n   <= 1'b1;
      credits     <= credits_next;
      cmd_ready_q <= (credits_next != '0);
    end
  end

  // Pins carry a command for exactly one cycle, otherwise the idle pattern.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spu_ui_in  <= 8'h00;
      spu_uio_in <= IDLE_UIO;
    end else if (accept) begin
      spu_ui_in  <= pack_ui(cmd);
      spu_uio_in <= pack_uio(cmd);
    end else begin
      spu_ui_in  <= 8'h00;
      spu_uio_in <= IDLE_UIO;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_vld  <= '0;
      inflight <= '0;
      for (int i = 0; i < int'(STAGES); i++) stg_op[i] <= '0;
    end else begin
      stg_vld   <= {stg_vld[STAGES-2:0], accept};
      inflight  <= 3'($countones({stg_vld[STAGES-2:0], accept}));
      stg_op[0] <= host.cmd_op;
      for (int i = 1; i < int'(STAGES); i++) stg_op[i] <= stg_op[i-1];
    end
  end

  assign capture = stg_vld[STAGES-1];
  assign cap_op  = stg_op[STAGES-1];

  // Reserved opcodes must come back as zero; any other value latches the error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_nonzero <= 1'b0;
    end else if (capture && is_rsvd(cap_op) && (spu_uo_out != 8'h00)) begin
      err_nonzero <= 1'b1;
    end
  end

  assign fifo_wdata = {cap_op, spu_uo_out};

  spu_host_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (capture),
    .wr_data (fifo_wdata),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .count   (fifo_count)
  );

  assign host.cmd_ready = cmd_ready_q;
  assign host.rsp_valid = (fifo_count != '0);
  assign host.rsp_data  = fifo_head.data;
  assign host.rsp_op    = fifo_head.op;

endmodule

// File: tb/tb_spu_host_sequencer.sv
// Scoreboard bench for spu_host_sequencer with a table-driven two-stage SPU model.
module tb_spu_host_sequencer;
  import spu_host_pkg::*;

  localparam int unsigned LATENCY    = 2;
  localparam int unsigned FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] spu_ui_in;
  logic [7:0] spu_uio_in;
  logic [7:0] spu_uo_out;
  logic       spu_rst_n;
  logic       err_nonzero;
  logic [2:0] inflight;

  spu_host_sequencer_if hif ();

  spu_host_sequencer #(.LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .host        (hif),
    .spu_ui_in   (spu_ui_in),
    .spu_uio_in  (spu_uio_in),
    .spu_uo_out  (spu_uo_out),
    .spu_rst_n   (spu_rst_n),
    .err_nonzero (err_nonzero),
    .inflight    (inflight)
  );

  always #5 clk = ~clk;

  // SPU stand-in: result looked up by ui_in, delivered two edges after the pins.
  logic [7:0] model_mem [256];
  logic [7:0] spu_s1;
  always @(posedge clk or negedge spu_rst_n) begin
    if (!spu_rst_n) begin
      spu_s1     <= '0;
      spu_uo_out <= '0;
    end else begin
      spu_s1     <= model_mem[spu_ui_in];
      spu_uo_out <= spu_s1;
    end
  end

  rsp_t exp_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_rsp    = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare whenever a response handshake is pending.
  always @(negedge clk) begin
    rsp_t e;
    if (reset !== 1'b1) begin
      check("outstanding_le_depth", 8'(exp_q.size() <= int'(FIFO_DEPTH)), 8'd1);
      if (hif.rsp_valid && hif.rsp_ready) begin
        n_rsp++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got data 0x%0h op %0d, required no response", hif.rsp_data, hif.rsp_op);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", hif.rsp_data, e.data);
          check("rsp_op", 8'(hif.rsp_op), 8'(e.op));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] c,
                      input logic [2:0] d, input logic [1:0] op);
    bit   done;
    rsp_t e;
    done = 1'b0;
    hif.cmd_a = a; hif.cmd_b = b; hif.cmd_c = c; hif.cmd_d = d; hif.cmd_op = op;
    hif.cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (hif.cmd_ready) begin
        e.op   = op;
        e.data = model_mem[{b, a}];
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("cmd_accepted", 8'(done), 8'd1);
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 50) begin
      @(negedge clk);
      i++;
    end
    check("drain_empty", 8'(exp_q.size()), 8'd0);
    @(negedge clk);
  endtask

  task automatic offer_bp(input int cycles, inout int acc);
    rsp_t e;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      hif.cmd_a = 4'(acc); hif.cmd_b = 4'h4; hif.cmd_c = 3'd0; hif.cmd_d = 3'd0;
      hif.cmd_op = OP_MANHATTAN;
      hif.cmd_valid = (acc < 6);
      if (hif.cmd_valid && hif.cmd_ready) begin
        e.op   = OP_MANHATTAN;
        e.data = model_mem[64 + acc];
        exp_q.push_back(e);
        acc++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    hif.cmd_valid = 1'b0;
  endtask

  initial begin
    int base;
    int acc;
    reset = 1'b1;
    hif.cmd_valid = 1'b0;
    hif.cmd_a = '0; hif.cmd_b = '0; hif.cmd_c = '0; hif.cmd_d = '0; hif.cmd_op = '0;
    hif.rsp_ready = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;

    repeat (2) @(negedge clk);
    check("rst_ui", spu_ui_in, 8'h00);
    check("rst_uio", spu_uio_in, IDLE_UIO);
    check("rst_spu_rst_n", 8'(spu_rst_n), 8'd0);
    check("rst_cmd_ready", 8'(hif.cmd_ready), 8'd0);
    check("rst_rsp_valid", 8'(hif.rsp_valid), 8'd0);
    check("rst_rsp_data", hif.rsp_data, 8'h00);
    check("rst_rsp_op", 8'(hif.rsp_op), 8'd0);
    check("rst_err", 8'(err_nonzero), 8'd0);
    check("rst_inflight", 8'(inflight), 8'd0);

    reset = 1'b0;
    #1 check("spu_rst_n_before_edge", 8'(spu_rst_n), 8'd0);
    @(posedge clk);
    #1 check("spu_rst_n_after_edge", 8'(spu_rst_n), 8'd1);
    check("cmd_ready_after_rst", 8'(hif.cmd_ready), 8'd1);
    @(negedge clk);
    hif.rsp_ready = 1'b1;

    // Pin packing and accept-to-response latency
    model_mem[8'hA3] = 8'h5A;
    send(4'h3, 4'hA, 3'd5, 3'd2, OP_AREA);
    hif.cmd_valid = 1'b0;
    check("pin_ui_issue", spu_ui_in, 8'hA3);
    check("pin_uio_issue", spu_uio_in, 8'h55);
    check("inflight_one", 8'(inflight), 8'd1);
    @(negedge clk);
    check("pin_ui_idle", spu_ui_in, 8'h00);
    check("pin_uio_idle", spu_uio_in, IDLE_UIO);
    check("lat_valid_t1", 8'(hif.rsp_valid), 8'd0);
    @(negedge clk);
    check("lat_valid_t2", 8'(hif.rsp_valid), 8'd0);
    @(negedge clk);
    check("lat_valid_t3", 8'(hif.rsp_valid), 8'd1);
    check("lat_data", hif.rsp_data, 8'h5A);
    check("lat_op", 8'(hif.rsp_op), 8'(OP_AREA));
    check("lat_inflight_zero", 8'(inflight), 8'd0);
    wait_drain();

    // Streaming: eight commands offered back-to-back, results 0..7 in order
    base = n_rsp;
    for (int i = 0; i < 8; i++) model_mem[16 + i] = 8'(i);
    for (int i = 0; i < 8; i++)
      send(4'(i), 4'h1, 3'(i), 3'(7 - i), (i % 2 == 1) ? OP_AREA : OP_MANHATTAN);
    hif.cmd_valid = 1'b0;
    wait_drain();
    check("stream_count", 8'(n_rsp - base), 8'd8);
    check("stream_err_clear", 8'(err_nonzero), 8'd0);

    // Reserved opcode returning nonzero sets the sticky error
    model_mem[8'h11] = 8'h01;
    send(4'h1, 4'h1, 3'd0, 3'd0, OP_RSVD3);
    hif.cmd_valid = 1'b0;
    wait_drain();
    check("err_set", 8'(err_nonzero), 8'd1);
    model_mem[8'h22] = 8'h00;
    send(4'h2, 4'h2, 3'd3, 3'd4, OP_RSVD2);
    hif.cmd_valid = 1'b0;
    wait_drain();
    check("err_sticky", 8'(err_nonzero), 8'd1);

    // Reset while three commands are in flight
    for (int i = 0; i < 3; i++) model_mem[8'h31 + i] = 8'h77;
    send(4'h1, 4'h3, 3'd1, 3'd1, OP_AREA);
    send(4'h2, 4'h3, 3'd2, 3'd2, OP_AREA);
    send(4'h3, 4'h3, 3'd3, 3'd3, OP_AREA);
    hif.cmd_valid = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_inflight", 8'(inflight), 8'd0);
    check("mid_rst_ui", spu_ui_in, 8'h00);
    check("mid_rst_uio", spu_uio_in, IDLE_UIO);
    check("mid_rst_spu_rst_n", 8'(spu_rst_n), 8'd0);
    check("mid_rst_cmd_ready", 8'(hif.cmd_ready), 8'd0);
    check("mid_rst_rsp_valid", 8'(hif.rsp_valid), 8'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("mid_rel_spu_rst_n_low", 8'(spu_rst_n), 8'd0);
    @(posedge clk);
    #1 check("mid_rel_spu_rst_n_high", 8'(spu_rst_n), 8'd1);
    check("mid_rel_cmd_ready", 8'(hif.cmd_ready), 8'd1);
    check("mid_rel_err_clear", 8'(err_nonzero), 8'd0);
    base = n_rsp;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("mid_rel_no_rsp", 8'(hif.rsp_valid), 8'd0);
    end
    check("mid_rel_rsp_count", 8'(n_rsp - base), 8'd0);

    // Backpressure: only FIFO_DEPTH commands fit, one pop frees one credit
    hif.rsp_ready = 1'b0;
    base = n_rsp;
    for (int k = 0; k < 6; k++) model_mem[64 + k] = 8'(128 + k);
    acc = 0;
    offer_bp(10, acc);
    check("bp_accepted", 8'(acc), 8'd4);
    check("bp_cmd_ready_low", 8'(hif.cmd_ready), 8'd0);
    check("bp_inflight_zero", 8'(inflight), 8'd0);
    check("bp_rsp_valid", 8'(hif.rsp_valid), 8'd1);
    check("bp_head", hif.rsp_data, 8'h80);
    @(negedge clk);
    check("bp_head_stable", hif.rsp_data, 8'h80);
    @(posedge clk);
    #1 hif.rsp_ready = 1'b1;
    @(posedge clk);
    #1 hif.rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_cmd_ready_after_pop", 8'(hif.cmd_ready), 8'd1);
    check("bp_head_after_pop", hif.rsp_data, 8'h81);
    offer_bp(6, acc);
    check("bp_one_more", 8'(acc), 8'd5);
    check("bp_cmd_ready_low2", 8'(hif.cmd_ready), 8'd0);
    @(posedge clk);
    #1 hif.rsp_ready = 1'b1;
    @(negedge clk);
    wait_drain();
    check("bp_rsp_count", 8'(n_rsp - base), 8'd5);
    check("final_queue_empty", 8'(exp_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
